maze_dfs_sequencer: RTL and testbench

- Controller that drives the grid-mover datapath (10x10 maze walker with visited tracking) to run a depth-first search toward the goal cell.
- Issues one move command at a time and checks the reported position to see whether each move was taken.
- Keeps a LIFO of taken directions so it can backtrack out of dead ends using the mover's backtrack-override move.
- Reports done/fail status and a step count to the top level.

---
 rtl/maze_dfs_sequencer_if.sv | 19 +
 rtl/maze_dfs_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_maze_dfs_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_dfs_sequencer_if.sv
// Move-command link between the DFS sequencer (master) and the grid mover (slave).
interface maze_dfs_sequencer_if;
  logic       mv_valid;
  logic [2:0] mv_dir;
  logic       mv_bt;
  logic [3:0] x_pos;
  logic [3:0] y_pos;
  logic       found;

  modport master (
    output mv_valid, mv_dir, mv_bt,
    input  x_pos, y_pos, found
  );

  modport slave (
    input  mv_valid, mv_dir, mv_bt,
    output x_pos, y_pos, found
  );
endinterface

// File: rtl/maze_dfs_sequencer.sv
// Depth-first search controller for the 10x10 grid mover, with a LIFO of taken directions.
// Optional watchdog: define MAZE_SEQ_TIMEOUT_EN to add the cycle limit and the timeout port.
module maze_dfs_sequencer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 4096,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned SPW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  maze_dfs_sequencer_if.master mv,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 ovf,
  output logic [CNT_W-1:0]     steps,
  output logic [SPW-1:0]       sp
`ifdef MAZE_SEQ_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  typedef enum logic [2:0] {StIdle, StIssue, StCheck, StPop, StBtWait, StDone, StFail} state_e;

  state_e     state_q;
  logic [2:0] try_q;
  logic [3:0] prev_x_q, prev_y_q;
  logic [1:0] stack [DEPTH];

  logic             moved, full, sp_nz;
  logic [1:0]       top;
  logic [CNT_W-1:0] steps_inc;

  assign moved     = (mv.x_pos != prev_x_q) || (mv.y_pos != prev_y_q);
  assign full      = (sp == SPW'(DEPTH));
  assign sp_nz     = (sp != '0);
  assign top       = stack[AW'(sp - SPW'(1))];
  assign steps_inc = (steps == '1) ? steps : steps + 1'b1;

`ifdef MAZE_SEQ_TIMEOUT_EN
  localparam int unsigned CYC_W = $clog2(MAX_CYCLES + 1);
  logic [CYC_W-1:0] cyc_q;
`endif

  // Outputs are registered: the backtrack command is prepared on entry to StPop using the
  // current top of stack, which cannot change until StPop itself pops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      try_q       <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      mv.mv_valid <= 1'b0;
      mv.mv_dir   <= '0;
      mv.mv_bt    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      ovf         <= 1'b0;
      steps       <= '0;
      sp          <= '0;
`ifdef MAZE_SEQ_TIMEOUT_EN
      cyc_q       <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      mv.mv_valid <= 1'b0;
      mv.mv_bt    <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StFail: begin
          if (start) begin
            done  <= 1'b0;
            fail  <= 1'b0;
            ovf   <= 1'b0;
            steps <= '0;
            sp    <= '0;
            try_q <= '0;
            if (mv.found) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              busy        <= 1'b1;
              mv.mv_valid <= 1'b1;
              mv.mv_dir   <= 3'd0;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          prev_x_q <= mv.x_pos;
          prev_y_q <= mv.y_pos;
          state_q  <= StCheck;
        end
        StCheck: begin
          if (mv.found) begin
            if (moved) begin
              if (!full) begin
                stack[sp[AW-1:0]] <= try_q[1:0];
                sp                <= sp + 1'b1;
              end
              steps <= steps_inc;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else if (moved && full) begin
            fail    <= 1'b1;
            ovf     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StFail;
          end else if (moved) begin
            stack[sp[AW-1:0]] <= try_q[1:0];
            sp                <= sp + 1'b1;
            steps             <= steps_inc;
            try_q             <= '0;
            mv.mv_valid       <= 1'b1;
            mv.mv_dir         <= 3'd0;
            state_q           <= StIssue;
          end else if (try_q == 3'd3) begin
            try_q       <= 3'd4;
            mv.mv_valid <= sp_nz;
            mv.mv_bt    <= sp_nz;
            mv.mv_dir   <= {1'b0, top ^ 2'b01};
            state_q     <= StPop;
          end else begin
            try_q       <= try_q + 3'd1;
            mv.mv_valid <= 1'b1;
            mv.mv_dir   <= try_q + 3'd1;
            state_q     <= StIssue;
          end
        end
        StPop: begin
          if (!sp_nz) begin
            fail    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StFail;
          end else begin
            sp      <= sp - 1'b1;
            try_q   <= {1'b0, top} + 3'd1;
            state_q <= StBtWait;
          end
        end
        StBtWait: begin
          if (try_q[2]) begin
            mv.mv_valid <= sp_nz;
            mv.mv_bt    <= sp_nz;
            mv.mv_dir   <= {1'b0, top ^ 2'b01};
            state_q     <= StPop;
          end else begin
            mv.mv_valid <= 1'b1;
            mv.mv_dir   <= try_q;
            state_q     <= StIssue;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase

`ifdef MAZE_SEQ_TIMEOUT_EN
      if (start && !busy) begin
        cyc_q   <= '0;
        timeout <= 1'b0;
      end else if (busy) begin
        cyc_q <= cyc_q + 1'b1;
      end
      // Watchdog wins over whatever transition the case above chose.
      if (busy && cyc_q == CYC_W'(MAX_CYCLES)) begin
        mv.mv_valid <= 1'b0;
        mv.mv_bt    <= 1'b0;
        fail        <= 1'b1;
        ovf         <= 1'b0;
        timeout     <= 1'b1;
        busy        <= 1'b0;
        state_q     <= StFail;
      end
`endif
    end
  end

endmodule

// File: tb/tb_maze_dfs_sequencer.sv
// Bench for maze_dfs_sequencer: table of hand-built mazes, random mazes against a plain DFS
// model, plus reset-abort and start-at-goal sequences.
`timescale 1ns/1ps
module tb_maze_dfs_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SPW   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, start;
  logic             busy, done, fail, ovf;
  logic [CNT_W-1:0] steps;
  logic [SPW-1:0]   sp;
`ifdef MAZE_SEQ_TIMEOUT_EN
  logic             timeout;
`endif

  maze_dfs_sequencer_if mif ();

  maze_dfs_sequencer #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (4096)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mv    (mif),
    .busy  (busy),
    .done  (done),
    .fail  (fail),
    .ovf   (ovf),
    .steps (steps),
    .sp    (sp)
`ifdef MAZE_SEQ_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Grid mover model: blocked cells, visited bits, 1-cycle move latency.
  logic [99:0] blk;
  logic [99:0] vis;
  logic [3:0]  cx, cy, gx, gy, lx, ly;
  logic        load_req;

  assign mif.x_pos = cx;
  assign mif.y_pos = cy;
  assign mif.found = (cx == gx) && (cy == gy);

  function automatic int nbx(input int x, input int d);
    return x + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
  endfunction

  function automatic int nby(input int y, input int d);
    return y + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
  endfunction

  function automatic bit open_cell(input int x, input int y);
    return (x >= 0) && (x < 10) && (y >= 0) && (y < 10) && !blk[y*10+x];
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      cx             <= lx;
      cy             <= ly;
      vis            <= '0;
      vis[ly*10+lx]  <= 1'b1;
    end else if (mif.mv_valid && int'(mif.mv_dir) < 4 &&
                 open_cell(nbx(int'(cx), int'(mif.mv_dir)), nby(int'(cy), int'(mif.mv_dir))) &&
                 (mif.mv_bt || !vis[nby(int'(cy), int'(mif.mv_dir))*10 +
                                    nbx(int'(cx), int'(mif.mv_dir))])) begin
      cx <= 4'(nbx(int'(cx), int'(mif.mv_dir)));
      cy <= 4'(nby(int'(cy), int'(mif.mv_dir)));
      vis[nby(int'(cy), int'(mif.mv_dir))*10 + nbx(int'(cx), int'(mif.mv_dir))] <= 1'b1;
    end
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference DFS: expected command stream (dir, +4 when backtrack) and final status.
  int exp_cmds[$];
  bit m_done, m_fail, m_ovf;
  int m_steps, m_sp;

  task automatic model(input int sx, input int sy, input int ggx, input int ggy);
    bit mvis[100];
    int stk[$];
    int x, y, t, nx, ny, d;
    exp_cmds.delete();
    foreach (mvis[i]) mvis[i] = 1'b0;
    mvis[sy*10+sx] = 1'b1;
    x = sx; y = sy; t = 0;
    m_done = 0; m_fail = 0; m_ovf = 0; m_steps = 0;
    if (sx == ggx && sy == ggy) begin
      m_done = 1;
    end else begin
      forever begin
        if (t < 4) begin
          exp_cmds.push_back(t);
          nx = nbx(x, t);
          ny = nby(y, t);
          if (open_cell(nx, ny) && !mvis[ny*10+nx]) begin
            mvis[ny*10+nx] = 1'b1;
            if (nx == ggx && ny == ggy) begin
              if (stk.size() < DEPTH) stk.push_back(t);
              m_steps++;
              m_done = 1;
              break;
            end
            if (stk.size() == DEPTH) begin
              m_fail = 1;
              m_ovf  = 1;
              break;
            end
            stk.push_back(t);
            m_steps++;
            x = nx; y = ny; t = 0;
          end else begin
            t++;
          end
        end else if (stk.size() == 0) begin
          m_fail = 1;
          break;
        end else begin
          d = stk.pop_back();
          exp_cmds.push_back(4 + (d ^ 1));
          x = nbx(x, d ^ 1);
          y = nby(y, d ^ 1);
          t = d + 1;
        end
      end
    end
    m_sp = stk.size();
  endtask

  task automatic open_at(input int x, input int y);
    blk[y*10+x] = 1'b0;
  endtask

  task automatic build_maze(input int id);
    blk = '1;
    case (id)
      1: for (int x = 2; x <= 5; x++) open_at(x, 5);
      2: begin open_at(2, 2); open_at(2, 3); open_at(2, 4); open_at(3, 2); end
      3: open_at(5, 5);
      4: open_at(0, 0);
      5: begin
        for (int x = 0; x <= 5; x++) open_at(x, 0);
        for (int y = 1; y <= 5; y++) open_at(5, y);
      end
      6: open_at(4, 4);
      7: for (int y = 7; y <= 9; y++) open_at(9, y);
      default: blk = '0;
    endcase
  endtask

  task automatic load_mover(input int sx, input int sy, input int ggx, input int ggy);
    gx = 4'(ggx); gy = 4'(ggy); lx = 4'(sx); ly = 4'(sy);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Runs one search, checking every command against the model stream.
  task automatic run_search(input int sx, input int sy, input int ggx, input int ggy,
                            input string name, output int ncmd);
    int  guard;
    bit  prev_v;
    int  code, want;
    model(sx, sy, ggx, ggy);
    load_mover(sx, sy, ggx, ggy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncmd = 0; guard = 0; prev_v = 0;
    while (busy && guard < 3000) begin
      if (mif.mv_valid) begin
        code = int'(mif.mv_dir) + (mif.mv_bt ? 4 : 0);
        want = (ncmd < exp_cmds.size()) ? exp_cmds[ncmd] : -1;
        if (code != want || prev_v) begin
          chk({name, "_cmd"}, code, prev_v ? -2 : want);
        end else begin
          checks++;
        end
        ncmd++;
      end
      prev_v = mif.mv_valid;
      @(negedge clk);
      guard++;
    end
    chk({name, "_terminated"}, guard < 3000, 1);
    chk({name, "_ncmd"}, ncmd, exp_cmds.size());
    chk({name, "_mv_valid_idle"}, mif.mv_valid, 0);
  endtask

  typedef struct {
    int maze;
    int sx, sy, gx, gy;
    bit e_done, e_fail, e_ovf;
    int e_steps, e_sp, e_ncmd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{1, 2, 5, 5, 5, 1, 0, 0, 3, 3, 12};  // straight corridor
    vecs[1] = '{2, 2, 2, 3, 2, 1, 0, 0, 3, 1, 14};  // dead end, two backtracks
    vecs[2] = '{3, 5, 5, 0, 0, 0, 1, 0, 0, 0, 4};   // enclosed
    vecs[3] = '{4, 0, 0, 9, 9, 0, 1, 0, 0, 0, 4};   // enclosed in corner
    vecs[4] = '{5, 0, 0, 5, 5, 0, 1, 1, 8, 8, 28};  // overflow on ninth move
    vecs[5] = '{6, 4, 4, 4, 4, 1, 0, 0, 0, 0, 0};   // start at goal
    vecs[6] = '{7, 9, 9, 9, 7, 1, 0, 0, 2, 2, 2};   // edge column, upward

    rst = 1'b1; start = 1'b0;
    blk = '1; gx = '0; gy = '0; lx = '0; ly = '0; load_req = 1'b1;
    repeat (3) @(negedge clk);
    load_req = 1'b0;
    chk("rst_mv_valid", mif.mv_valid, 0);
    chk("rst_mv_dir", mif.mv_dir, 0);
    chk("rst_mv_bt", mif.mv_bt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_steps", steps, 0);
    chk("rst_sp", sp, 0);
`ifdef MAZE_SEQ_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      build_maze(vecs[i].maze);
      run_search(vecs[i].sx, vecs[i].sy, vecs[i].gx, vecs[i].gy, nm, n);
      chk({nm, "_count"}, n, vecs[i].e_ncmd);
      chk({nm, "_done"}, done, vecs[i].e_done);
      chk({nm, "_fail"}, fail, vecs[i].e_fail);
      chk({nm, "_ovf"}, ovf, vecs[i].e_ovf);
      chk({nm, "_steps"}, steps, vecs[i].e_steps);
      chk({nm, "_sp"}, sp, vecs[i].e_sp);
      chk({nm, "_busy"}, busy, 0);
    end

    // Random mazes against the reference DFS.
    for (int r = 0; r < 30; r++) begin
      int sx, sy, ggx, ggy;
      for (int c = 0; c < 100; c++) blk[c] = ($urandom_range(99) < 40);
      sx = $urandom_range(9); sy = $urandom_range(9);
      ggx = $urandom_range(9); ggy = $urandom_range(9);
      open_at(sx, sy);
      open_at(ggx, ggy);
      run_search(sx, sy, ggx, ggy, $sformatf("rnd%0d", r), n);
      chk("rnd_done", done, m_done);
      chk("rnd_fail", fail, m_fail);
      chk("rnd_ovf", ovf, m_ovf);
      chk("rnd_steps", steps, m_steps);
      chk("rnd_sp", sp, m_sp);
    end

    // Reset in the middle of a search, after five commands.
    build_maze(0);
    load_mover(0, 0, 9, 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int g = 0; g < 200 && n < 5; g++) begin
      if (mif.mv_valid) n++;
      if (n < 5) @(negedge clk);
    end
    chk("midrst_reached", n, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_steps", steps, 0);
    chk("midrst_sp", sp, 0);
    chk("midrst_done_fail", {done, fail, ovf}, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += mif.mv_valid + busy;
    end
    chk("midrst_quiet", n, 0);
    build_maze(1);
    run_search(2, 5, 5, 5, "after_rst", n);
    chk("after_rst_done", done, 1);
    chk("after_rst_steps", steps, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
